// File: rtl/sram_rw0_sequencer_if.sv
// sram_rw0_sequencer_if
// Request/response channel between cache control logic (master) and the RW0
// SRAM sequencer (slave).
//   req_valid/req_ready   request handshake, fire when both high
//   req_write             1 = masked write, 0 = read
//   req_addr/wdata/wmask  request fields
//   resp_valid/resp_ready response handshake, pop when both high
//   resp_rdata            read data (0 for write acks)
//   resp_write            head entry is a write ack
interface sram_rw0_sequencer_if #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned MASK_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [MASK_WIDTH-1:0] req_wmask;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_write;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_write
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_write
    );
endinterface

// File: rtl/sram_rw0_sequencer.sv
// sram_rw0_sequencer
// Initiator-side controller for a single-port RW0 SRAM macro. Turns a
// valid/ready request stream into RW0 port controls, captures read data the
// cycle after issue and returns it in order through a credit-limited FIFO.
// Ports:
//   clock, reset  sole clock (also the macro's RW0_clk), synchronous active-high reset
//   bus           sram_rw0_sequencer_if.slave request/response channel
//   RW0_addr/en/wmode/wmask/wdata  macro controls, driven combinationally on fire
//   RW0_rdata     macro read data, valid only the cycle after a read issue
// Optional feature: define SRAM_RW0_SEQ_WRITE_ACK_EN to return an ack entry
// (resp_write=1, resp_rdata=0) for every write, in order with reads.
module sram_rw0_sequencer #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned MASK_WIDTH = 32,
    parameter int unsigned DEPTH      = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    sram_rw0_sequencer_if.slave   bus,
    output logic [ADDR_WIDTH-1:0] RW0_addr,
    output logic                  RW0_en,
    output logic                  RW0_wmode,
    output logic [MASK_WIDTH-1:0] RW0_wmask,
    output logic [DATA_WIDTH-1:0] RW0_wdata,
    input  logic [DATA_WIDTH-1:0] RW0_rdata
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic                  rd_pending_q;
    logic                  wr_pending_q;
    logic [OCC_W-1:0]      occ;
    logic                  fire, push, pop;
    logic                  req_ready, resp_valid;
    logic [DATA_WIDTH-1:0] push_data;
    logic [DATA_WIDTH-1:0] mem_data [DEPTH];

    // Credits: every in-flight capture counts against the FIFO so a push can
    // never find it full.
    assign occ       = OCC_W'(count_q) + OCC_W'(rd_pending_q) + OCC_W'(wr_pending_q);
    assign req_ready = !reset && (occ < OCC_W'(DEPTH));
    assign fire      = bus.req_valid && req_ready;

    assign RW0_en    = fire;
    assign RW0_wmode = bus.req_write;
    assign RW0_addr  = bus.req_addr;
    assign RW0_wdata = bus.req_wdata;
    assign RW0_wmask = bus.req_wmask;

    // At most one of the pending flags is set, since at most one fire per cycle.
    assign push      = rd_pending_q || wr_pending_q;
    assign push_data = rd_pending_q ? RW0_rdata : '0;

    assign resp_valid = !reset && (count_q != '0);
    assign pop        = resp_valid && bus.resp_ready;

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_rdata = mem_data[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rd_pending_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            rd_pending_q <= fire && !bus.req_write;
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_data[wr_ptr_q] <= push_data;
        end
    end

`ifdef SRAM_RW0_SEQ_WRITE_ACK_EN
    logic [DEPTH-1:0] mem_write;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_pending_q <= 1'b0;
        end else begin
            wr_pending_q <= fire && bus.req_write;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_write[wr_ptr_q] <= wr_pending_q;
        end
    end

    assign bus.resp_write = mem_write[rd_ptr_q];
`else
    assign wr_pending_q   = 1'b0;
    assign bus.resp_write = 1'b0;
`endif

    // Overflow is excluded by the credit check above.
    always_ff @(posedge clock) begin
        if (!reset && push) begin
            assert (count_q != CNT_W'(DEPTH));
        end
    end

endmodule

// File: tb/tb_sram_rw0_sequencer.sv
module tb_sram_rw0_sequencer;

    localparam int unsigned AW    = 9;
    localparam int unsigned DW    = 256;
    localparam int unsigned MW    = 32;
    localparam int unsigned DEPTH = 3;
`ifdef SRAM_RW0_SEQ_WRITE_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] RW0_addr;
    logic          RW0_en;
    logic          RW0_wmode;
    logic [MW-1:0] RW0_wmask;
    logic [DW-1:0] RW0_wdata;
    logic [DW-1:0] RW0_rdata;

    sram_rw0_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) bus ();

    sram_rw0_sequencer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .DEPTH(DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .RW0_addr  (RW0_addr),
        .RW0_en    (RW0_en),
        .RW0_wmode (RW0_wmode),
        .RW0_wmask (RW0_wmask),
        .RW0_wdata (RW0_wdata),
        .RW0_rdata (RW0_rdata)
    );

    always #5 clock = ~clock;

    // Macro model: read data follows the last read address, so a later write
    // to that address changes RW0_rdata one cycle after the read.
    logic [DW-1:0] mem [512];
    logic [AW-1:0] rd_addr_q = '0;
    assign RW0_rdata = mem[rd_addr_q];

    always @(posedge clock) begin
        if (RW0_en) begin
            if (RW0_wmode) begin
                for (int l = 0; l < MW; l++)
                    if (RW0_wmask[l]) mem[RW0_addr][l*8 +: 8] <= RW0_wdata[l*8 +: 8];
            end else begin
                rd_addr_q <= RW0_addr;
            end
        end
    end

    // Reference model: shadow memory updated in request order, plus the queue
    // of outstanding (credit-holding) responses with their fire cycle.
    typedef struct {
        logic [DW-1:0] data;
        logic          wr;
        int unsigned   cyc;
    } exp_t;

    logic [DW-1:0] ref_mem [512];
    exp_t          exp_q [$];
    int unsigned   cyc = 0;
    int unsigned   fire_cnt = 0;
    int            n_tests = 0;
    int            n_fail = 0;
    bit            rr_rand = 1'b0;
    bit            rr_val = 1'b1;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clock) begin
        if (reset) begin
            chk("reset_req_ready", DW'(bus.req_ready), '0);
            chk("reset_resp_valid", DW'(bus.resp_valid), '0);
            chk("reset_rw0_en", DW'(RW0_en), '0);
            exp_q.delete();
        end else begin
            bit       credit_ok;
            bit       head_due;
            credit_ok = exp_q.size() < DEPTH;
            head_due  = 1'b0;
            if (exp_q.size() > 0) head_due = cyc >= exp_q[0].cyc + 2;
            chk("req_ready", DW'(bus.req_ready), DW'(credit_ok));
            chk("resp_valid", DW'(bus.resp_valid), DW'(head_due));
            chk("rw0_en", DW'(RW0_en), DW'(bus.req_valid && credit_ok));
            if (bus.resp_valid && bus.resp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", DW'(1), DW'(0));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("resp_rdata", bus.resp_rdata, e.data);
                    chk("resp_write", DW'(bus.resp_write), DW'(e.wr));
                end
            end
            if (bus.req_valid && bus.req_ready) begin
                exp_t e;
                fire_cnt++;
                chk("rw0_addr", DW'(RW0_addr), DW'(bus.req_addr));
                chk("rw0_wmode", DW'(RW0_wmode), DW'(bus.req_write));
                e.cyc = cyc;
                if (bus.req_write) begin
                    chk("rw0_wdata", RW0_wdata, bus.req_wdata);
                    chk("rw0_wmask", DW'(RW0_wmask), DW'(bus.req_wmask));
                    for (int l = 0; l < MW; l++)
                        if (bus.req_wmask[l])
                            ref_mem[bus.req_addr][l*8 +: 8] = bus.req_wdata[l*8 +: 8];
                    e.data = '0;
                    e.wr   = 1'b1;
                    if (ACK) exp_q.push_back(e);
                end else begin
                    e.data = ref_mem[bus.req_addr];
                    e.wr   = 1'b0;
                    exp_q.push_back(e);
                end
            end
        end
    end

    initial forever begin
        @(posedge clock);
        #1;
        bus.resp_ready = rr_rand ? ($urandom_range(0, 3) != 0) : rr_val;
    end

    // Offer a request and hold it until it fires (bounded).
    task automatic do_req(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [MW-1:0] m);
        bit rdy;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_wmask = m;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            rdy = bus.req_ready;
            @(posedge clock);
            #1;
            if (rdy) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL req_timeout: addr %0h never accepted", a);
    endtask

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    initial begin
        int unsigned t0;
        int unsigned f0;
        logic [DW-1:0] ones;
        bit done3;
        ones = '1;
        for (int i = 0; i < 512; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_wmask  = '0;
        bus.resp_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // 1: write then read same address
        do_req(1'b1, 9'h005, {32{8'hA5}}, '1);
        do_req(1'b0, 9'h005, '0, '0);
        idle(6);

        // 2: eight back-to-back reads at full rate
        t0 = cyc;
        for (int i = 0; i < 8; i++) do_req(1'b0, AW'(i), '0, '0);
        chk("burst_cycles", DW'(cyc - t0), DW'(8));
        idle(6);

        // 3: backpressure with credit limit
        rr_val = 1'b0;
        idle(1);
        f0    = fire_cnt;
        done3 = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) do_req(1'b0, AW'(i + 1), '0, '0);
                bus.req_valid = 1'b0;
                done3 = 1'b1;
            end
        join_none
        repeat (8) @(posedge clock);
        #1;
        chk("bp_fires", DW'(fire_cnt - f0), DW'(DEPTH));
        chk("bp_ready_low", DW'(bus.req_ready), '0);
        rr_val = 1'b1;
        for (int i = 0; i < 100 && !done3; i++) @(posedge clock);
        #1;
        chk("bp_done", DW'(done3), DW'(1));
        idle(6);

        // 4: read-then-write hazard and masked write
        do_req(1'b1, 9'h010, {32{8'h11}}, '1);
        idle(1);
        do_req(1'b0, 9'h010, '0, '0);
        do_req(1'b1, 9'h010, {32{8'h22}}, '1);
        do_req(1'b0, 9'h010, '0, '0);
        do_req(1'b1, 9'h010, {32{8'h33}}, 32'h0000_0001);
        do_req(1'b0, 9'h010, '0, '0);
        idle(6);

        // 5: reset with responses queued
        rr_val = 1'b0;
        idle(1);
        for (int i = 0; i < 3; i++) do_req(1'b0, AW'(i), '0, '0);
        bus.req_valid = 1'b0;
        reset = 1'b1;
        idle(2);
        reset  = 1'b0;
        rr_val = 1'b1;
        idle(10);
        chk("post_reset_empty", DW'(exp_q.size()), '0);

        // 6: read, write, read ordering (acks only with the write-ack build)
        do_req(1'b0, 9'h020, '0, '0);
        do_req(1'b1, 9'h020, {32{8'h5A}}, '1);
        do_req(1'b0, 9'h020, '0, '0);
        idle(6);

        // Random traffic against the reference model
        rr_rand = 1'b1;
        for (int n = 0; n < 400; n++) begin
            bit w;
            logic [MW-1:0] m;
            w = ($urandom_range(0, 2) == 0);
            m = ($urandom_range(0, 1) == 0) ? ones[MW-1:0] : MW'($urandom);
            do_req(w, AW'($urandom_range(0, 15)), rnd_data(), m);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        rr_rand = 1'b0;
        rr_val  = 1'b1;
        idle(20);
        chk("drain_empty", DW'(exp_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
